// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, FSM state and transaction-owner encodings for the memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 64;
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_MASK_W = DEF_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single shared memory port between instruction fetch and load/store,
// one outstanding transaction at a time, with load/store taking priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_rdata,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic              ls_req_we,
    input  logic [DATA_W-1:0] ls_req_wdata,
    input  logic [MASK_W-1:0] ls_req_wmask,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    output logic              busy,
    output logic              err_spurious_rsp
);

    arb_state_t        state_q, state_d;
    owner_t            owner_q;
    logic              drop_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;
    logic              err_q;

    always_comb begin
        state_d      = state_q;
        if_req_ready = 1'b0;
        ls_req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (ls_req_valid) begin
                    ls_req_ready = 1'b1;
                    state_d      = ISSUE;
                end else if (if_req_valid && !if_flush) begin
                    if_req_ready = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: if (mem_req_ready) state_d = WAIT;
            WAIT:  if (mem_rsp_valid) state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            drop_q     <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;

            if (ls_req_ready) begin
                owner_q <= OWN_LS;
                addr_q  <= ls_req_addr;
                we_q    <= ls_req_we;
                wdata_q <= ls_req_wdata;
                wmask_q <= ls_req_we ? ls_req_wmask : '0;
            end else if (if_req_ready) begin
                owner_q <= OWN_IF;
                drop_q  <= 1'b0;
                addr_q  <= if_req_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end

            // A squashed fetch still finishes on the bus; only its response is suppressed.
            if (if_flush && state_q != IDLE && owner_q == OWN_IF) drop_q <= 1'b1;

            if (state_q == WAIT && mem_rsp_valid) begin
                if (owner_q == OWN_LS) ls_rdata_q <= we_q ? '0 : mem_rsp_rdata;
                else                   if_rdata_q <= mem_rsp_rdata;
            end

            if (mem_rsp_valid && state_q != WAIT) err_q <= 1'b1;
        end
    end

    assign mem_req_valid    = (state_q == ISSUE);
    assign mem_req_addr     = addr_q;
    assign mem_req_we       = we_q;
    assign mem_req_wdata    = wdata_q;
    assign mem_req_wmask    = wmask_q;
    assign if_rsp_valid     = (state_q == RESP) && (owner_q == OWN_IF) && !drop_q && !if_flush;
    assign ls_rsp_valid     = (state_q == RESP) && (owner_q == OWN_LS);
    assign if_rsp_rdata     = if_rdata_q;
    assign ls_rsp_rdata     = ls_rdata_q;
    assign busy             = (state_q != IDLE);
    assign err_spurious_rsp = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized transaction-level checks of mem_port_arbiter against a reference model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0, if_req_ready, if_flush = 1'b0, if_rsp_valid;
    logic [63:0] if_req_addr = '0, if_rsp_rdata;
    logic        ls_req_valid = 1'b0, ls_req_ready, ls_req_we = 1'b0, ls_rsp_valid;
    logic [63:0] ls_req_addr = '0, ls_req_wdata = '0, ls_rsp_rdata;
    logic [7:0]  ls_req_wmask = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_we;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_rdata = '0;
    logic        busy, err_spurious_rsp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MASK_W(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
        .ls_req_we(ls_req_we), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .busy(busy), .err_spurious_rsp(err_spurious_rsp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_quiet_outputs(input string tag);
        chk({tag, "_if_ready"}, if_req_ready, 0);
        chk({tag, "_ls_ready"}, ls_req_ready, 0);
        chk({tag, "_if_rsp"}, if_rsp_valid, 0);
        chk({tag, "_ls_rsp"}, ls_rsp_valid, 0);
    endtask

    // One complete transaction: grant, ISSUE with wi stall cycles, WAIT with wr idle cycles,
    // then the response pulse. flush_at: 0 none, 1 ISSUE, 2 WAIT, 3 RESP.
    task automatic run_txn(input bit has_ls, input bit has_if, input bit we,
                           input logic [63:0] la, input logic [63:0] wd, input logic [7:0] wm,
                           input logic [63:0] ia, input int wi, input int wr,
                           input int flush_at, input bit idle_flush, input logic [63:0] rd);
        bit own_ls, dropped;
        logic [63:0] e_addr, e_wdata;
        logic e_we;
        logic [7:0] e_wmask;
        own_ls  = has_ls;
        dropped = 1'b0;
        e_addr  = own_ls ? la : ia;
        e_we    = own_ls ? we : 1'b0;
        e_wdata = own_ls ? wd : 64'd0;
        e_wmask = (own_ls && we) ? wm : 8'd0;

        ls_req_valid = has_ls; ls_req_we = we; ls_req_addr = la;
        ls_req_wdata = wd; ls_req_wmask = wm;
        if_req_valid = has_if; if_req_addr = ia;
        if (idle_flush && !has_ls && has_if) begin
            if_flush = 1'b1;
            #1;
            chk("idle_flush_blocks_if", if_req_ready, 0);
            tick();
            chk("idle_flush_no_busy", busy, 0);
            if_flush = 1'b0;
        end
        #1;
        chk("grant_ls", ls_req_ready, has_ls);
        chk("grant_if", if_req_ready, !has_ls && has_if);
        tick();
        if (own_ls) ls_req_valid = 1'b0; else if_req_valid = 1'b0;

        for (int i = 0; i <= wi; i++) begin
            mem_req_ready = (i == wi);
            if_flush = (flush_at == 1 && i == 0);
            #1;
            if (if_flush && !own_ls) dropped = 1'b1;
            chk("issue_valid", mem_req_valid, 1);
            chk("issue_addr", mem_req_addr, e_addr);
            chk("issue_we", mem_req_we, e_we);
            chk("issue_wdata", mem_req_wdata, e_wdata);
            chk("issue_wmask", mem_req_wmask, e_wmask);
            chk("issue_busy", busy, 1);
            chk_quiet_outputs("issue");
            tick();
            if_flush = 1'b0;
        end
        mem_req_ready = 1'b0;

        for (int i = 0; i <= wr; i++) begin
            mem_rsp_valid = (i == wr);
            mem_rsp_rdata = (i == wr) ? rd : ~rd;
            if_flush = (flush_at == 2 && i == 0);
            #1;
            if (if_flush && !own_ls) dropped = 1'b1;
            chk("wait_no_req", mem_req_valid, 0);
            chk_quiet_outputs("wait");
            tick();
            if_flush = 1'b0;
        end
        mem_rsp_valid = 1'b0;

        if_flush = (flush_at == 3);
        #1;
        if (if_flush && !own_ls) dropped = 1'b1;
        chk("resp_ls_pulse", ls_rsp_valid, own_ls);
        chk("resp_if_pulse", if_rsp_valid, !own_ls && !dropped);
        if (own_ls) chk("resp_ls_rdata", ls_rsp_rdata, we ? 64'd0 : rd);
        else if (!dropped) chk("resp_if_rdata", if_rsp_rdata, rd);
        chk("resp_no_req", mem_req_valid, 0);
        tick();
        if_flush = 1'b0;
        #1;
        chk("after_if_pulse", if_rsp_valid, 0);
        chk("after_ls_pulse", ls_rsp_valid, 0);
        chk("after_busy", busy, 0);
    endtask

    initial begin
        bit pend_if;
        logic [63:0] pend_addr;

        // Reset state
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_mem_addr", mem_req_addr, 0);
        chk("rst_err", err_spurious_rsp, 0);
        chk("rst_if_rdata", if_rsp_rdata, 0);
        tick(); tick();
        rst = 1'b0;

        // Reset mid-WAIT, then a stray response lands in IDLE
        if_req_valid = 1'b1; if_req_addr = 64'h1234;
        tick();
        if_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1; chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", mem_req_addr, 0);
        tick();
        rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hABCD;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("stray_err", err_spurious_rsp, 1);
        chk("stray_no_if_pulse", if_rsp_valid, 0);
        chk("stray_busy", busy, 0);
        tick(); #1;
        chk("err_sticky", err_spurious_rsp, 1);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("err_cleared", err_spurious_rsp, 0);
        tick();

        // Zero-wait IF fetch
        run_txn(0, 1, 0, 0, 0, 0, 64'h8000_0000, 0, 0, 0, 0, 64'h0000_0013_0000_0297);
        // Simultaneous requests: LS store wins, IF follows right after
        run_txn(1, 1, 1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 64'h8000_0004, 0, 0, 0, 0, 64'h5555);
        run_txn(0, 1, 0, 0, 0, 0, 64'h8000_0004, 0, 0, 0, 0, 64'h0000_0000_0000_0073);
        // Downstream stalls for 5 cycles in ISSUE
        run_txn(1, 0, 0, 64'h8000_2000, 64'h77, 8'hFF, 0, 5, 2, 0, 0, 64'hCAFE_F00D);
        // Fetch flushed while waiting, then a normal fetch
        run_txn(0, 1, 0, 0, 0, 0, 64'h8000_0008, 0, 3, 2, 0, 64'h1111);
        run_txn(0, 1, 0, 0, 0, 0, 64'h8000_0100, 0, 0, 0, 0, 64'h2222);
        // Flush in IDLE holds off the grant for one cycle
        run_txn(0, 1, 0, 0, 0, 0, 64'h8000_0200, 1, 1, 0, 1, 64'h3333);
        // Flush against an LS transaction is ignored
        run_txn(1, 0, 0, 64'h10, 0, 0, 0, 0, 0, 2, 0, 64'h4444);

        // Randomized mix
        pend_if = 1'b0;
        pend_addr = '0;
        for (int n = 0; n < 40; n++) begin
            bit hl, hi;
            logic [63:0] ia;
            hl = $urandom_range(0, 1);
            hi = pend_if ? 1'b1 : 1'($urandom_range(0, 1));
            if (!hl && !hi) hi = 1'b1;
            ia = pend_if ? pend_addr : {$urandom, $urandom};
            run_txn(hl, hi, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                    8'($urandom), ia, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 4), 1'($urandom_range(0, 1)), {$urandom, $urandom});
            pend_if = hl && hi;
            pend_addr = ia;
        end
        if (pend_if) run_txn(0, 1, 0, 0, 0, 0, pend_addr, 0, 0, 0, 0, 64'h9);
        chk("no_spurious_after_random", err_spurious_rsp, 0);

        // Response coincident with request acceptance is flagged and ignored
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0300;
        tick();
        if_req_valid = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hBAD;
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        chk("accept_rsp_err", err_spurious_rsp, 1);
        chk("accept_rsp_ignored_busy", busy, 1);
        chk("accept_rsp_no_pulse", if_rsp_valid, 0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h600D;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("accept_rsp_real_pulse", if_rsp_valid, 1);
        chk("accept_rsp_real_data", if_rsp_rdata, 64'h600D);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
